cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter.sv | 114 +++++++++++
 tb/tb_cdb_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter with registered broadcast and saturating count
// Round-robin arbitration when CDB_ARB_ROUND_ROBIN_EN is defined, fixed lowest-index priority otherwise.
module cdb_arbiter #(
   parameter int NREQ = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*4-1:0] req_id,
   input  logic [NREQ*8-1:0] req_val,
   input  logic              flush,
   output logic [NREQ-1:0]   grant,
   output logic              cdb_valid,
   output logic [3:0]        cdb_id,
   output logic [7:0]        cdb_val,
   output logic [15:0]       bcast_count
);

   logic [NREQ-1:0] w_grant;
   logic            w_any;
   logic [3:0]      w_sel_id;
   logic [7:0]      w_sel_val;

   logic            r_cdb_valid;
   logic [3:0]      r_cdb_id;
   logic [7:0]      r_cdb_val;
   logic [15:0]     r_bcast_count;

`ifdef CDB_ARB_ROUND_ROBIN_EN
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_next_ptr;
   int            w_dist;
   int            w_best;

   // Winner is the requester closest to r_ptr going upward with wrap.
   always_comb begin
      w_grant    = '0;
      w_any      = 1'b0;
      w_sel_id   = '0;
      w_sel_val  = '0;
      w_next_ptr = r_ptr;
      w_dist     = 0;
      w_best     = NREQ;
      for (int j = 0; j < NREQ; j++) begin
         w_dist = (j >= int'(r_ptr)) ? (j - int'(r_ptr)) : (j + NREQ - int'(r_ptr));
         if (req[j] && (w_dist < w_best)) begin
            w_best     = w_dist;
            w_any      = 1'b1;
            w_grant    = '0;
            w_grant[j] = 1'b1;
            w_sel_id   = req_id[4*j +: 4];
            w_sel_val  = req_val[8*j +: 8];
            w_next_ptr = (j == NREQ - 1) ? '0 : PW'(j + 1);
         end
      end
      if (rst || flush) begin
         w_grant = '0;
         w_any   = 1'b0;
      end
   end
`else
   always_comb begin
      w_grant   = '0;
      w_any     = 1'b0;
      w_sel_id  = '0;
      w_sel_val = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (req[j] && !w_any) begin
            w_any      = 1'b1;
            w_grant[j] = 1'b1;
            w_sel_id   = req_id[4*j +: 4];
            w_sel_val  = req_val[8*j +: 8];
         end
      end
      if (rst || flush) begin
         w_grant = '0;
         w_any   = 1'b0;
      end
   end
`endif

   // Losers are not latched; the FU keeps presenting its result until granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cdb_valid   <= 1'b0;
         r_cdb_id      <= '0;
         r_cdb_val     <= '0;
         r_bcast_count <= '0;
`ifdef CDB_ARB_ROUND_ROBIN_EN
         r_ptr         <= '0;
`endif
      end else begin
         r_cdb_valid <= w_any;
         if (w_any) begin
            r_cdb_id  <= w_sel_id;
            r_cdb_val <= w_sel_val;
            if (r_bcast_count != 16'hFFFF)
               r_bcast_count <= r_bcast_count + 16'd1;
`ifdef CDB_ARB_ROUND_ROBIN_EN
            r_ptr <= w_next_ptr;
`endif
         end
      end
   end

   assign grant       = w_grant;
   assign cdb_valid   = r_cdb_valid;
   assign cdb_id      = r_cdb_id;
   assign cdb_val     = r_cdb_val;
   assign bcast_count = r_bcast_count;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter (either CDB_ARB_ROUND_ROBIN_EN setting)
module tb_cdb_arbiter;

   localparam int NREQ = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [15:0] req_id = '0;
   logic [31:0] req_val = '0;
   logic        flush = 1'b0;
   logic [3:0]  grant;
   logic        cdb_valid;
   logic [3:0]  cdb_id;
   logic [7:0]  cdb_val;
   logic [15:0] bcast_count;

   int n_vec = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   cdb_arbiter #(.NREQ(NREQ)) dut (
      .clk(clk), .rst(rst), .req(req), .req_id(req_id), .req_val(req_val),
      .flush(flush), .grant(grant), .cdb_valid(cdb_valid), .cdb_id(cdb_id),
      .cdb_val(cdb_val), .bcast_count(bcast_count)
   );

   typedef struct {
      logic        do_rst;
      logic [3:0]  req;
      logic        flush;
      logic [3:0]  g;
      logic        v;
      logic [3:0]  id;
      logic [7:0]  val;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      req   = 4'b1111;
      flush = 1'b0;
      #1;
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_valid", 32'(cdb_valid), 32'h0);
      chk("rst_id", 32'(cdb_id), 32'h0);
      chk("rst_val", 32'(cdb_val), 32'h0);
      chk("rst_cnt", 32'(bcast_count), 32'h0);
      req = '0;
      #1 rst = 1'b0;
   endtask

   // Reference model state
   int          m_ptr;
   int          m_cnt;
   logic        m_valid;
   logic [3:0]  m_id;
   logic [7:0]  m_val;

   initial begin
      int w;
      int idx;
      logic [3:0] eg;

      // Lane data: id 3/7/5/9, value 11/22/A3/44
      req_id  = {4'h9, 4'h5, 4'h7, 4'h3};
      req_val = {8'h44, 8'hA3, 8'h22, 8'h11};

`ifdef CDB_ARB_ROUND_ROBIN_EN
      tbl[0]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'h5, 8'hA3, 16'd1};
      tbl[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 1'b1, 4'h3, 8'h11, 16'd1};
      tbl[2]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 4'h7, 8'h22, 16'd2};
      tbl[3]  = '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 4'h5, 8'hA3, 16'd3};
      tbl[4]  = '{1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 4'h9, 8'h44, 16'd4};
      tbl[5]  = '{1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0, 4'h9, 8'h44, 16'd4};
      tbl[6]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'h3, 8'h11, 16'd5};
      tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'h3, 8'h11, 16'd5};
      tbl[8]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 4'h7, 8'h22, 16'd6};
      tbl[9]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'h7, 8'h22, 16'd6};
      tbl[10] = '{1'b0, 4'b1001, 1'b0, 4'b1000, 1'b1, 4'h9, 8'h44, 16'd7};
      tbl[11] = '{1'b0, 4'b1001, 1'b0, 4'b0001, 1'b1, 4'h3, 8'h11, 16'd8};
`else
      tbl[0]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'h5, 8'hA3, 16'd1};
      tbl[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 1'b1, 4'h3, 8'h11, 16'd1};
      tbl[2]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 4'h3, 8'h11, 16'd2};
      tbl[3]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 4'h3, 8'h11, 16'd3};
      tbl[4]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 4'h3, 8'h11, 16'd4};
      tbl[5]  = '{1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0, 4'h3, 8'h11, 16'd4};
      tbl[6]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'h3, 8'h11, 16'd5};
      tbl[7]  = '{1'b0, 4'b1010, 1'b0, 4'b0010, 1'b1, 4'h7, 8'h22, 16'd6};
      tbl[8]  = '{1'b0, 4'b1010, 1'b0, 4'b0010, 1'b1, 4'h7, 8'h22, 16'd7};
      tbl[9]  = '{1'b0, 4'b1010, 1'b0, 4'b0010, 1'b1, 4'h7, 8'h22, 16'd8};
      tbl[10] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'h7, 8'h22, 16'd8};
      tbl[11] = '{1'b0, 4'b1100, 1'b1, 4'b0000, 1'b0, 4'h7, 8'h22, 16'd8};
`endif

      for (int i = 0; i < 12; i++) begin
         if (tbl[i].do_rst) do_reset();
         @(negedge clk);
         req   = tbl[i].req;
         flush = tbl[i].flush;
         #1;
         chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_valid", i), 32'(cdb_valid), 32'(tbl[i].v));
         chk($sformatf("tbl%0d_id", i), 32'(cdb_id), 32'(tbl[i].id));
         chk($sformatf("tbl%0d_val", i), 32'(cdb_val), 32'(tbl[i].val));
         chk($sformatf("tbl%0d_cnt", i), 32'(bcast_count), 32'(tbl[i].cnt));
      end
      flush = 1'b0;

      // Reset between a grant edge and the next edge drops the in-flight broadcast
      do_reset();
      @(negedge clk);
      req = 4'b0100;
      #1 chk("mid_grant", 32'(grant), 32'h4);
      @(posedge clk);
      #1 chk("mid_valid", 32'(cdb_valid), 32'h1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(cdb_valid), 32'h0);
      chk("mid_rst_cnt", 32'(bcast_count), 32'h0);
      chk("mid_rst_grant", 32'(grant), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      req = 4'b1111;
      #1 chk("post_rst_grant", 32'(grant), 32'h1);
      @(posedge clk);
      #1 chk("post_rst_id", 32'(cdb_id), 32'h3);

      // Counter saturation
      do_reset();
      @(negedge clk);
      req = 4'b0001;
      repeat (65534) @(posedge clk);
      #1 chk("sat_fffe", 32'(bcast_count), 32'hFFFE);
      @(posedge clk);
      #1 chk("sat_1", 32'(bcast_count), 32'hFFFF);
      repeat (2) @(posedge clk);
      #1 chk("sat_3", 32'(bcast_count), 32'hFFFF);
      chk("sat_valid", 32'(cdb_valid), 32'h1);

      // Randomised traffic against the reference model
      do_reset();
      m_ptr = 0; m_cnt = 0; m_valid = 1'b0; m_id = '0; m_val = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         req     = 4'($urandom);
         flush   = ($urandom_range(0, 7) == 0);
         req_id  = 16'($urandom);
         req_val = $urandom;
         w  = -1;
         eg = '0;
         if (!flush) begin
            for (int k = 0; k < NREQ; k++) begin
`ifdef CDB_ARB_ROUND_ROBIN_EN
               idx = (m_ptr + k) % NREQ;
`else
               idx = k;
`endif
               if (w < 0 && req[idx]) w = idx;
            end
         end
         if (w >= 0) eg[w] = 1'b1;
         #1 chk("rnd_grant", 32'(grant), 32'(eg));
         @(posedge clk);
         if (w >= 0) begin
            m_valid = 1'b1;
            m_id    = req_id[w*4 +: 4];
            m_val   = req_val[w*8 +: 8];
            if (m_cnt < 65535) m_cnt++;
            m_ptr = (w + 1) % NREQ;
         end else begin
            m_valid = 1'b0;
         end
         #1;
         chk("rnd_valid", 32'(cdb_valid), 32'(m_valid));
         chk("rnd_id", 32'(cdb_id), 32'(m_id));
         chk("rnd_val", 32'(cdb_val), 32'(m_val));
         chk("rnd_cnt", 32'(bcast_count), 32'(m_cnt));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
